// File: rtl/rv32i_types_pkg.sv
// Shared types and constants for the memory-side arbitration logic.
package rv32i_types_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arbiter_state_t;

  localparam int ARB_STARVE_LIMIT = 2;
  localparam logic [3:0] FULL_WORD_BE = 4'b1111;

endpackage

// File: rtl/generic_bus_if.sv
// Simple word bus: the master drives request fields, the slave answers with busy/rdata.
interface generic_bus_if;

  logic        ren;
  logic        wen;
  logic        busy;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  byte_en;

  modport generic_bus (
    input  ren, wen, addr, wdata, byte_en,
    output busy, rdata
  );

  modport cpu (
    output ren, wen, addr, wdata, byte_en,
    input  busy, rdata
  );

endinterface

// File: rtl/ooo_mem_arbiter.sv
// Two-requester (fetch / data) arbiter onto one shared memory bus.
// Data wins ties until fetch has waited STARVE_LIMIT consecutive data grants.
module ooo_mem_arbiter
  import rv32i_types_pkg::*;
#(
  parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
  input  logic           CLK,
  input  logic           RST,
  generic_bus_if.generic_bus igen_bus_if,
  generic_bus_if.generic_bus dgen_bus_if,
  generic_bus_if.cpu     mem_gen_bus_if,
  output arbiter_state_t grant_state
);

  localparam logic [1:0] LIMIT = 2'(STARVE_LIMIT);

  arbiter_state_t state_reg;
  logic [1:0]     starve_cnt_reg;
  logic           i_req;
  logic           d_req;

  assign i_req = igen_bus_if.ren;
  assign d_req = dgen_bus_if.ren | dgen_bus_if.wen;

  // Fetch is read-only; its write-side fields are deliberately ignored.
  logic unused_igen;
  assign unused_igen = ^{igen_bus_if.wen, igen_bus_if.wdata, igen_bus_if.byte_en};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg      <= IDLE;
      starve_cnt_reg <= 2'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (d_req && (!i_req || starve_cnt_reg < LIMIT)) begin
            state_reg <= SERVE_D;
            if (i_req && starve_cnt_reg < LIMIT)
              starve_cnt_reg <= starve_cnt_reg + 2'd1;
          end else if (i_req) begin
            state_reg      <= SERVE_I;
            starve_cnt_reg <= 2'd0;
          end
        end
        // Completion or withdrawal both return to IDLE, leaving a one-cycle bubble.
        SERVE_I: if (!i_req || !mem_gen_bus_if.busy) state_reg <= IDLE;
        SERVE_D: if (!d_req || !mem_gen_bus_if.busy) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign grant_state = state_reg;

  assign igen_bus_if.rdata = mem_gen_bus_if.rdata;
  assign dgen_bus_if.rdata = mem_gen_bus_if.rdata;

  always_comb begin
    mem_gen_bus_if.ren     = 1'b0;
    mem_gen_bus_if.wen     = 1'b0;
    mem_gen_bus_if.addr    = '0;
    mem_gen_bus_if.wdata   = '0;
    mem_gen_bus_if.byte_en = '0;
    igen_bus_if.busy       = 1'b1;
    dgen_bus_if.busy       = 1'b1;
    case (state_reg)
      SERVE_I: begin
        mem_gen_bus_if.ren     = igen_bus_if.ren;
        mem_gen_bus_if.addr    = igen_bus_if.addr;
        mem_gen_bus_if.byte_en = FULL_WORD_BE;
        igen_bus_if.busy       = mem_gen_bus_if.busy;
      end
      SERVE_D: begin
        mem_gen_bus_if.ren     = dgen_bus_if.ren;
        mem_gen_bus_if.wen     = dgen_bus_if.wen;
        mem_gen_bus_if.addr    = dgen_bus_if.addr;
        mem_gen_bus_if.wdata   = dgen_bus_if.wdata;
        mem_gen_bus_if.byte_en = dgen_bus_if.byte_en;
        dgen_bus_if.busy       = mem_gen_bus_if.busy;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ooo_mem_arbiter.sv
// Scoreboard bench: a transaction-level owner/streak model predicts every cycle's outputs.
module tb_ooo_mem_arbiter;
  import rv32i_types_pkg::*;

  localparam int LIMIT = ARB_STARVE_LIMIT;

  typedef struct packed {
    logic [1:0]  gs;
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ibusy;
    logic        dbusy;
    logic [31:0] irdata;
    logic [31:0] drdata;
  } obs_t;

  logic           CLK = 1'b0;
  logic           RST;
  arbiter_state_t grant_state;

  generic_bus_if ibus ();
  generic_bus_if dbus ();
  generic_bus_if mbus ();

  ooo_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .igen_bus_if    (ibus),
    .dgen_bus_if    (dbus),
    .mem_gen_bus_if (mbus),
    .grant_state    (grant_state)
  );

  always #5 CLK = ~CLK;

  obs_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Model: who owns the bus (0 none, 1 fetch, 2 data) and how many data grants fetch has sat through.
  int   m_owner = 0;
  int   m_streak = 0;
  bit   i_done, d_done;

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      obs_t e, a;
      e = exp_q.pop_front();
      a = {grant_state, mbus.ren, mbus.wen, mbus.addr, mbus.wdata, mbus.byte_en,
           ibus.busy, dbus.busy, ibus.rdata, dbus.rdata};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL cycle_outputs @%0t: got gs=%0d ren=%b wen=%b addr=%h wdata=%h be=%b ib=%b db=%b ird=%h drd=%h, want gs=%0d ren=%b wen=%b addr=%h wdata=%h be=%b ib=%b db=%b ird=%h drd=%h",
                 $time, a.gs, a.ren, a.wen, a.addr, a.wdata, a.be, a.ibusy, a.dbusy, a.irdata, a.drdata,
                 e.gs, e.ren, e.wen, e.addr, e.wdata, e.be, e.ibusy, e.dbusy, e.irdata, e.drdata);
      end
      if (mbus.ren && mbus.wen) begin
        miscompares++;
        $display("FAIL ren_wen_exclusive @%0t: got ren=%b wen=%b, want not both", $time, mbus.ren, mbus.wen);
      end
    end
  end

  task automatic set_i(input bit r, input logic [31:0] a);
    ibus.ren  = r;
    ibus.addr = a;
  endtask

  task automatic set_d(input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
    dbus.ren     = r;
    dbus.wen     = w;
    dbus.addr    = a;
    dbus.wdata   = wd;
    dbus.byte_en = be;
  endtask

  // Predict this cycle from current inputs, queue it, advance the model, then step one clock.
  task automatic tick();
    obs_t e;
    bit iq, dq;
    iq = ibus.ren;
    dq = dbus.ren | dbus.wen;
    e = '0;
    e.gs = 2'(m_owner);
    e.ibusy = 1'b1;
    e.dbusy = 1'b1;
    e.irdata = mbus.rdata;
    e.drdata = mbus.rdata;
    i_done = 1'b0;
    d_done = 1'b0;
    if (m_owner == 1) begin
      e.ren = ibus.ren;
      e.addr = ibus.addr;
      e.be = 4'hF;
      e.ibusy = mbus.busy;
      i_done = iq && !mbus.busy;
    end else if (m_owner == 2) begin
      e.ren = dbus.ren;
      e.wen = dbus.wen;
      e.addr = dbus.addr;
      e.wdata = dbus.wdata;
      e.be = dbus.byte_en;
      e.dbusy = mbus.busy;
      d_done = dq && !mbus.busy;
    end
    exp_q.push_back(e);
    if (RST) begin
      m_owner = 0;
      m_streak = 0;
    end else if (m_owner == 0) begin
      if (dq && (!iq || m_streak < LIMIT)) begin
        m_owner = 2;
        if (iq) m_streak++;
      end else if (iq) begin
        m_owner = 1;
        m_streak = 0;
      end
    end else if (m_owner == 1) begin
      if (!(iq && mbus.busy)) m_owner = 0;
    end else begin
      if (!(dq && mbus.busy)) m_owner = 0;
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    bit i_act, d_act;
    RST = 1'b1;
    set_i(0, 0);
    ibus.wen = 0; ibus.wdata = 0; ibus.byte_en = 0;
    set_d(0, 0, 0, 0, 0);
    mbus.busy = 1'b0;
    mbus.rdata = 32'h0;
    @(posedge CLK);
    #1;
    tick();
    RST = 1'b0;

    // Single fetch, memory busy for two cycles of service.
    set_i(1, 32'h8000_0000);
    mbus.busy = 1'b1;
    tick(); tick(); tick();
    mbus.busy = 1'b0;
    mbus.rdata = 32'hCAFE_F00D;
    tick();
    set_i(0, 0);
    tick();

    // Simultaneous requests: data, data, then fetch.
    set_i(1, 32'h0000_0100);
    set_d(1, 0, 32'h0000_0200, 0, 4'hF);
    for (int k = 0; k < 8; k++) begin
      mbus.rdata = 32'h1000 + k;
      tick();
      if (i_done) set_i(0, 0);
    end
    set_d(0, 0, 0, 0, 0);
    set_i(0, 0);
    tick();

    // Partial-word store.
    set_d(0, 1, 32'h0000_1000, 32'hDEAD_BEEF, 4'b0011);
    mbus.busy = 1'b1;
    tick(); tick();
    mbus.busy = 1'b0;
    tick();
    set_d(0, 0, 0, 0, 0);
    tick();

    // Withdrawal while memory is busy.
    set_d(1, 0, 32'h0000_2000, 0, 4'hF);
    mbus.busy = 1'b1;
    tick(); tick();
    set_d(0, 0, 0, 0, 0);
    tick(); tick();

    // Reset in the middle of a fetch.
    set_i(1, 32'h0000_3000);
    tick(); tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    set_i(0, 0);
    mbus.busy = 1'b0;
    tick(); tick();

    // Random traffic: requests held until completion, occasional withdrawal and reset.
    i_act = 0;
    d_act = 0;
    for (int n = 0; n < 3000; n++) begin
      RST = ($urandom_range(0, 99) == 0);
      if (i_act && (i_done || $urandom_range(0, 39) == 0)) i_act = 0;
      if (d_act && (d_done || $urandom_range(0, 39) == 0)) d_act = 0;
      if (!i_act) begin
        set_i(0, $urandom);
        if ($urandom_range(0, 2) == 0) begin
          i_act = 1;
          set_i(1, $urandom);
        end
      end
      if (!d_act) begin
        set_d(0, 0, $urandom, $urandom, 4'($urandom));
        if ($urandom_range(0, 2) == 0) begin
          d_act = 1;
          if ($urandom_range(0, 1) == 0) set_d(1, 0, $urandom, $urandom, 4'($urandom));
          else                           set_d(0, 1, $urandom, $urandom, 4'($urandom));
        end
      end
      ibus.wen = 1'($urandom);
      ibus.wdata = $urandom;
      ibus.byte_en = 4'($urandom);
      mbus.busy = ($urandom_range(0, 2) != 0);
      mbus.rdata = $urandom;
      tick();
    end

    RST = 1'b0;
    tick();
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ooo_mem_arbiter.md
OOO_MEM_ARBITER -- requirements
Module: ooo_mem_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 2: the maximum number of consecutive data grants while an instruction request waits.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port igen_bus_if, generic_bus_if.generic_bus, interface width: the instruction-fetch requester (ren only; wen ignored).
REQ-005 The block SHALL have port dgen_bus_if, generic_bus_if.generic_bus, interface width: the data (LSU) requester (ren/wen).
REQ-006 The block SHALL have port mem_gen_bus_if, generic_bus_if.cpu, interface width: the single shared downstream bus.
REQ-007 The block SHALL have port grant_state, output, 2 bits: current arbiter_state_t, for debug/hazard use.

Function
REQ-008 The FSM SHALL have the states IDLE, SERVE_I and SERVE_D (arbiter_state_t).
REQ-009 The arbiter SHALL define request pending as i_req = igen.ren and d_req = dgen.ren | dgen.wen.
REQ-010 In IDLE, the arbiter SHALL make the next-state decision from the current-cycle requests:
- d_req & ~i_req -> SERVE_D.
- i_req & ~d_req -> SERVE_I.
- both requesting with starve_cnt < STARVE_LIMIT -> SERVE_D.
- both requesting with starve_cnt == STARVE_LIMIT -> SERVE_I.
- neither -> IDLE.
REQ-011 The grant SHALL be registered, so a request first seen in IDLE at cycle N drives the downstream bus at cycle N+1 (1-cycle arbitration latency).
REQ-012 In SERVE_x, the downstream addr, ren, wen, wdata and byte_en SHALL be combinationally muxed from requester x; for SERVE_I, wen=0, byte_en=4'b1111 and wdata=0.
REQ-013 In IDLE, the downstream ren, wen, addr, wdata and byte_en SHALL all be 0.
REQ-014 mem_gen_bus_if.rdata SHALL be forwarded combinationally to both requesters' rdata.
REQ-015 The requester busy outputs SHALL follow these rules:
- A granted requester's busy equals mem busy.
- A non-granted requester's busy is 1.
- In IDLE, both busy outputs are 1.
REQ-016 Completion SHALL be defined as being in SERVE_x with a downstream request asserted and mem busy == 0; on completion the next state is IDLE, giving a one-cycle bubble between grants.
REQ-017 If the granted requester deasserts its request while in SERVE_x, the next state SHALL be IDLE with no completion counted.
REQ-018 starve_cnt SHALL be a 2-bit saturating counter updated as follows:
- It increments on each IDLE->SERVE_D transition while i_req is high.
- It clears on each IDLE->SERVE_I transition.
- It holds otherwise.
- It never exceeds STARVE_LIMIT.
REQ-019 The arbiter SHALL never grant both requesters, and the downstream ren and wen SHALL never be asserted simultaneously by the arbiter.
REQ-020 A request that arrives while the other requester is being served SHALL be held off (busy=1) and considered at the next IDLE cycle.

Reset
REQ-021 When RST is high at a rising edge, the next state SHALL be IDLE and starve_cnt SHALL be 0, regardless of state.
REQ-022 Reset SHALL override completion and request events occurring in the same cycle.
REQ-023 During and immediately after reset, the outputs SHALL take these values:
- grant_state = IDLE.
- Downstream ren=0, wen=0, addr=0, wdata=0, byte_en=0.
- Both requester busy=1.
REQ-024 A reset mid-transaction SHALL abandon the transaction; the downstream slave is reset by the same RST.

Structure
REQ-025 arbiter_state_t (2-bit enum: IDLE=0, SERVE_I=1, SERVE_D=2) SHALL reside in rv32i_types_pkg.
REQ-026 The STARVE_LIMIT default SHALL be defined as constant ARB_STARVE_LIMIT in rv32i_types_pkg.
REQ-027 The design SHALL consist of a single module with no sub-modules.
REQ-028 The output mux SHALL be a separate combinational block driven only by the state register.

Verification
REQ-029 Scenario, single fetch: i ren at 0x80000000 with mem busy low after 2 cycles -> mem ren asserted from cycle 1; i busy=0 and rdata passed in the completion cycle; IDLE the next cycle.
REQ-030 Scenario, simultaneous requests with starve_cnt=0: i and d ren both high -> SERVE_D first and starve_cnt=1, then after completion SERVE_D again if d is still requesting (starve_cnt=2), then SERVE_I on the third grant and starve_cnt=0.
REQ-031 Scenario, data store: d wen, addr 0x1000, wdata 0xDEADBEEF, byte_en 4'b0011 -> mem sees identical values with ren=0; i busy stays 1 throughout.
REQ-032 Scenario, request withdrawal: d drops wen while in SERVE_D with mem busy high -> IDLE next cycle and starve_cnt unchanged.
REQ-033 Scenario, reset mid-operation: RST high while in SERVE_I with mem busy high -> next cycle IDLE, starve_cnt=0, mem ren=0, both busy=1.
REQ-034 All scenarios SHALL include assertions that there is never a dual grant and never ren&wen on the downstream bus.
